mips_alu: RTL and testbench
===========================

# mips_alu

Registered integer ALU for the MIPS execute stage: computes one R-type result (arithmetic, logical, shift, compare) per cycle from two operands, a 6-bit funct code and a 5-bit shift amount. The result is captured in an output register, so it is available to the EX/MEM boundary one clock after the operands are presented. RTL module name: `mips_alu`.

## Interface
Parameters:
- `NB_DATA`, 32: operand and result width (≥ 8).
- `NB_OP`, 6: operation (funct) code width.

Ports:
- Clocking is fixed: one clock; reset is asynchronous and active-low.
- `i_clk`, input, 1: clock; all state updates on the rising edge.
- `i_rst_n`, input, 1: asynchronous, active-low reset.
- `i_valid`, input, 1: operands and operation are valid this cycle.
- `i_datoA`, input, NB_DATA: operand A (rs); shift amount for variable shifts.
- `i_datoB`, input, NB_DATA: operand B (rt); value that is shifted in all shifts.
- `i_operation`, input, NB_OP: funct code.
- `i_shamt`, input, 5: immediate shift amount, unsigned.
- `o_data`, output, NB_DATA: registered result.
- `o_valid`, output, 1: `o_data` holds a new result.
- `o_zero`, output, 1: registered flag; high when `o_data == 0`.
- `o_overflow`, output, 1: present only with `ALU_OVERFLOW_EN`.

## Operation
Funct codes and the result each one produces (A = `i_datoA`, B = `i_datoB`):
- `000000` SLL: B << shamt.
- `000010` SRL: B >> shamt, logical.
- `000011` SRA: B >>> shamt, sign-filled.
- `000100` SLLV, `000110` SRLV, `000111` SRAV: same as SLL/SRL/SRA, but the amount is A[4:0].

Shift-amount rules:
- Amounts are unsigned, 0–31.
- If amount ≥ NB_DATA: logical shifts give 0; arithmetic shifts give all bits equal to B's sign bit.

Arithmetic, logic and compare:
- `100000` ADD, `100001` ADDU: A+B, modulo 2^NB_DATA.
- `100010` SUB, `100011` SUBU: A−B, modulo 2^NB_DATA.
- `100100` AND, `100101` OR, `100110` XOR, `100111` NOR: bitwise.
- `101010` SLT: 1 if A < B signed, else 0; result is zero-extended.
- `101011` SLTU: 1 if A < B unsigned, else 0; result is zero-extended.
- Any other code: result is 0.

Register update:
- `i_valid`=1: `o_data`, `o_zero` and `o_overflow` load the new result; `o_valid`=1.
- `i_valid`=0: `o_data`, `o_zero` and `o_overflow` hold their previous values; `o_valid`=0.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one operation per cycle; there is no backpressure.
- Reset values: `o_data`=0, `o_valid`=0, `o_zero`=1, `o_overflow`=0.
- Reset is asynchronous on assertion and does not wait for a clock edge.
- An operation in flight when reset asserts is discarded.
- The first result after reset release is the one sampled at the first rising edge with `i_valid`=1.

## Configuration
- Macro `ALU_OVERFLOW_EN` defined: port `o_overflow` exists.
  - ADD: overflow = 1 when A and B have the same sign and the result sign differs from it.
  - SUB: overflow = 1 when A and B differ in sign and the result sign differs from A.
  - All other operations, including ADDU and SUBU: overflow = 0.
  - `o_data` still takes the wrapped result.
- Macro not defined: no `o_overflow` port and no overflow logic.

## Structure
- Shared package `alu_pkg`:
  - localparams for all 16 funct codes (`ADD_OP`, `SRAV_OP`, …);
  - the shift-amount width (5).
- One sub-module, `alu_shifter`: combinational; takes B, the amount and the shift type; returns the shifted value.
- The combinational result mux and the output register stay in `mips_alu`.

## Test plan
All scenarios use NB_DATA=8.
- ADD 0x05+0x03 → 0x08 and SUB 0x07−0x02 → 0x05, each one cycle after `i_valid`; `o_valid` pulses for one cycle.
- SLL 0x01 by shamt 3 → 0x08; SRA 0xF8 by 2 → 0xFE; SRLV 0x08 by A=3 → 0x01; SRAV 0xF8 by A=3 → 0xFF; SRL 0x80 by 9 → 0x00.
- AND 0x0F,0xF0 → 0x00 with `o_zero`=1; OR → 0xFF; XOR → 0xFF; NOR → 0x00.
- SLT 0x01,0x02 → 1; SLT 0xFF,0x01 → 1; SLTU 0xFF,0x01 → 0.
- `ALU_OVERFLOW_EN` defined:
  - ADD 0x7F+0x01 → 0x80 with `o_overflow`=1;
  - ADDU 0x7F+0x01 → 0x80 with `o_overflow`=0;
  - SUB 0x80−0x01 → 0x7F with `o_overflow`=1.
- Reset and hold: assert `i_rst_n`=0 mid-stream → outputs go to their reset values without a clock edge. Drive `i_valid`=0 with new operands → `o_data` holds and `o_valid`=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared funct codes, shift-amount width and shift kinds for the MIPS execute-stage ALU.
package alu_pkg;

  localparam int SHAMT_W = 5;

  localparam logic [5:0] SLL_OP  = 6'b000000;
  localparam logic [5:0] SRL_OP  = 6'b000010;
  localparam logic [5:0] SRA_OP  = 6'b000011;
  localparam logic [5:0] SLLV_OP = 6'b000100;
  localparam logic [5:0] SRLV_OP = 6'b000110;
  localparam logic [5:0] SRAV_OP = 6'b000111;
  localparam logic [5:0] ADD_OP  = 6'b100000;
  localparam logic [5:0] ADDU_OP = 6'b100001;
  localparam logic [5:0] SUB_OP  = 6'b100010;
  localparam logic [5:0] SUBU_OP = 6'b100011;
  localparam logic [5:0] AND_OP  = 6'b100100;
  localparam logic [5:0] OR_OP   = 6'b100101;
  localparam logic [5:0] XOR_OP  = 6'b100110;
  localparam logic [5:0] NOR_OP  = 6'b100111;
  localparam logic [5:0] SLT_OP  = 6'b101010;
  localparam logic [5:0] SLTU_OP = 6'b101011;

  typedef enum logic [1:0] {
    SHIFT_LL,
    SHIFT_RL,
    SHIFT_RA
  } shift_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter shared by the immediate and variable shift instructions.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  logic [NB_DATA-1:0] b,
  input  logic [SHAMT_W-1:0] amt,
  input  shift_t             kind,
  output logic [NB_DATA-1:0] y
);

  // Amounts at or beyond NB_DATA fall out naturally: << and >> give 0, >>> gives sign fill.
  always_comb begin
    // NOTE: default assignment first so no path through the block can infer a latch.
    y = '0;
    case (kind)
      SHIFT_LL: y = b << amt;
      SHIFT_RL: y = b >> amt;
      SHIFT_RA: y = $signed(b) >>> amt;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// Registered MIPS R-type ALU: result, zero flag and valid appear one cycle after the operands.
// Optional o_overflow port and signed-overflow logic are enabled by defining ALU_OVERFLOW_EN.
module mips_alu
  import alu_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_datoA,
  input  logic [NB_DATA-1:0] i_datoB,
  input  logic [NB_OP-1:0]   i_operation,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_zero
`ifdef ALU_OVERFLOW_EN
  ,
  output logic               o_overflow
`endif
);

  logic [NB_DATA-1:0] sum;
  logic [NB_DATA-1:0] diff;
  logic [NB_DATA-1:0] shifted;
  logic [NB_DATA-1:0] result;
  logic [SHAMT_W-1:0] shift_amt;
  shift_t             shift_kind;

  assign sum  = i_datoA + i_datoB;
  assign diff = i_datoA - i_datoB;

  // Variable shifts take their amount from rs; immediate shifts from the shamt field.
  always_comb begin
    shift_kind = SHIFT_LL;
    shift_amt  = i_shamt;
    case (i_operation)
      SRL_OP:  shift_kind = SHIFT_RL;
      SRA_OP:  shift_kind = SHIFT_RA;
      SLLV_OP: shift_amt  = i_datoA[SHAMT_W-1:0];
      SRLV_OP: begin
        shift_kind = SHIFT_RL;
        shift_amt  = i_datoA[SHAMT_W-1:0];
      end
      SRAV_OP: begin
        shift_kind = SHIFT_RA;
        shift_amt  = i_datoA[SHAMT_W-1:0];
      end
      default: ;
    endcase
  end

  alu_shifter #(.NB_DATA(NB_DATA)) u_shifter (
    .b    (i_datoB),
    .amt  (shift_amt),
    .kind (shift_kind),
    .y    (shifted)
  );

  always_comb begin
    result = '0;
    case (i_operation)
      SLL_OP, SRL_OP, SRA_OP,
      SLLV_OP, SRLV_OP, SRAV_OP: result = shifted;
      ADD_OP, ADDU_OP:           result = sum;
      SUB_OP, SUBU_OP:           result = diff;
      AND_OP:                    result = i_datoA & i_datoB;
      OR_OP:                     result = i_datoA | i_datoB;
      XOR_OP:                    result = i_datoA ^ i_datoB;
      NOR_OP:                    result = ~(i_datoA | i_datoB);
      SLT_OP:                    result[0] = $signed(i_datoA) < $signed(i_datoB);
      SLTU_OP:                   result[0] = i_datoA < i_datoB;
      default:                   result = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic overflow;

  // Only the trapping forms flag overflow; ADDU/SUBU wrap silently.
  always_comb begin
    overflow = 1'b0;
    case (i_operation)
      ADD_OP: overflow = (i_datoA[NB_DATA-1] == i_datoB[NB_DATA-1]) &&
                         (sum[NB_DATA-1] != i_datoA[NB_DATA-1]);
      SUB_OP: overflow = (i_datoA[NB_DATA-1] != i_datoB[NB_DATA-1]) &&
                         (diff[NB_DATA-1] != i_datoA[NB_DATA-1]);
      default: ;
    endcase
  end
`endif

  // NOTE: sequential state uses non-blocking assignments; every output register is reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_zero     <= 1'b1;
`ifdef ALU_OVERFLOW_EN
      o_overflow <= 1'b0;
`endif
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data     <= result;
        o_zero     <= (result == '0);
`ifdef ALU_OVERFLOW_EN
        o_overflow <= overflow;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Scoreboard bench for mips_alu at NB_DATA=8: directed and random ops against an arithmetic model.
module tb_mips_alu;
  import alu_pkg::*;

  localparam int NB = 8;

  typedef struct {
    logic [NB-1:0] data;
    logic          zero;
    logic          ovf;
  } exp_t;

  typedef struct {
    logic [5:0]    op;
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [4:0]    sh;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [NB-1:0] dat_a = '0;
  logic [NB-1:0] dat_b = '0;
  logic [5:0]    op = '0;
  logic [4:0]    shamt = '0;
  logic [NB-1:0] out_data;
  logic          out_valid;
  logic          out_zero;
  logic          out_ovf;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t held;

  mips_alu #(.NB_DATA(NB), .NB_OP(6)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (in_valid),
    .i_datoA     (dat_a),
    .i_datoB     (dat_b),
    .i_operation (op),
    .i_shamt     (shamt),
    .o_data      (out_data),
    .o_valid     (out_valid),
    .o_zero      (out_zero)
`ifdef ALU_OVERFLOW_EN
    ,
    .o_overflow  (out_ovf)
`endif
  );

`ifndef ALU_OVERFLOW_EN
  assign out_ovf = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input vec_t v);
    exp_t   e;
    longint a = v.a, b = v.b, sa = sx(v.a), sb = sx(v.b), d, r = 0;
    bit     var_sh = (v.op == SLLV_OP) || (v.op == SRLV_OP) || (v.op == SRAV_OP);
    int     amt = var_sh ? int'(v.a % 32) : int'(v.sh);
    e.ovf = 1'b0;
    d = longint'(1) << amt;
    case (v.op)
      SLL_OP, SLLV_OP: r = (b * d) % 256;
      SRL_OP, SRLV_OP: r = b / d;
      SRA_OP, SRAV_OP: r = (sb >= 0) ? sb / d : -(((-sb) + d - 1) / d);
      ADD_OP:  begin r = sa + sb; e.ovf = (r > 127) || (r < -128); end
      ADDU_OP: r = a + b;
      SUB_OP:  begin r = sa - sb; e.ovf = (r > 127) || (r < -128); end
      SUBU_OP: r = a - b;
      AND_OP:  r = a & b;
      OR_OP:   r = a | b;
      XOR_OP:  r = a ^ b;
      NOR_OP:  r = 255 - (a | b);
      SLT_OP:  r = (sa < sb) ? 1 : 0;
      SLTU_OP: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    e.data = NB'(r & 255);
    e.zero = (e.data == 0);
`ifndef ALU_OVERFLOW_EN
    e.ovf = 1'b0;
`endif
    return e;
  endfunction

  task automatic issue(input vec_t v, input bit valid);
    @(posedge clk);
    #1;
    op = v.op; dat_a = v.a; dat_b = v.b; shamt = v.sh; in_valid = valid;
    if (valid) exp_q.push_back(model(v));
  endtask

  // Monitor: pops on every valid output, otherwise checks the held values.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data", 32'(out_data), 32'(e.data));
          check("zero", 32'(out_zero), 32'(e.zero));
          check("ovf", 32'(out_ovf), 32'(e.ovf));
          held = e;
        end
      end else begin
        check("hold_data", 32'(out_data), 32'(held.data));
        check("hold_zero", 32'(out_zero), 32'(held.zero));
        check("hold_ovf", 32'(out_ovf), 32'(held.ovf));
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_zero"}, 32'(out_zero), 32'd1);
    check({tag, "_ovf"}, 32'(out_ovf), 32'd0);
  endtask

  vec_t directed[$] = '{
    '{ADD_OP,  8'h05, 8'h03, 5'd0},
    '{SUB_OP,  8'h07, 8'h02, 5'd0},
    '{SLL_OP,  8'h00, 8'h01, 5'd3},
    '{SRA_OP,  8'h00, 8'hF8, 5'd2},
    '{SRLV_OP, 8'h03, 8'h08, 5'd0},
    '{SRAV_OP, 8'h03, 8'hF8, 5'd0},
    '{SRL_OP,  8'h00, 8'h80, 5'd9},
    '{SRA_OP,  8'h00, 8'h80, 5'd20},
    '{SRAV_OP, 8'hFF, 8'h40, 5'd0},
    '{SLLV_OP, 8'h08, 8'hFF, 5'd0},
    '{AND_OP,  8'h0F, 8'hF0, 5'd0},
    '{OR_OP,   8'h0F, 8'hF0, 5'd0},
    '{XOR_OP,  8'h0F, 8'hF0, 5'd0},
    '{NOR_OP,  8'h0F, 8'hF0, 5'd0},
    '{SLT_OP,  8'h01, 8'h02, 5'd0},
    '{SLT_OP,  8'hFF, 8'h01, 5'd0},
    '{SLTU_OP, 8'hFF, 8'h01, 5'd0},
    '{ADD_OP,  8'h7F, 8'h01, 5'd0},
    '{ADDU_OP, 8'h7F, 8'h01, 5'd0},
    '{SUB_OP,  8'h80, 8'h01, 5'd0},
    '{SUBU_OP, 8'h80, 8'h01, 5'd0},
    '{6'b111111, 8'h12, 8'h34, 5'd0}
  };

  logic [5:0] codes[16] = '{SLL_OP, SRL_OP, SRA_OP, SLLV_OP, SRLV_OP, SRAV_OP,
                            ADD_OP, ADDU_OP, SUB_OP, SUBU_OP, AND_OP, OR_OP,
                            XOR_OP, NOR_OP, SLT_OP, SLTU_OP};

  function automatic vec_t rand_vec();
    vec_t v;
    v.op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : codes[$urandom_range(0, 15)];
    v.a  = NB'($urandom);
    v.b  = NB'($urandom);
    v.sh = 5'($urandom);
    return v;
  endfunction

  initial begin
    int   waited;
    vec_t idle;
    held = '{data: '0, zero: 1'b1, ovf: 1'b0};
    idle = '{6'd0, 8'h00, 8'h00, 5'd0};

    #12;
    check_reset_values("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (directed[i]) issue(directed[i], 1'b1);
    issue(idle, 1'b0);

    // Idle cycles with fresh operands must not disturb the held result.
    for (int i = 0; i < 4; i++) issue(rand_vec(), 1'b0);

    for (int i = 0; i < 300; i++) issue(rand_vec(), ($urandom_range(0, 3) != 0));

    // Mid-stream asynchronous reset, asserted between clock edges.
    issue('{ADD_OP, 8'h11, 8'h22, 5'd0}, 1'b1);
    issue('{OR_OP, 8'h5A, 8'h00, 5'd0}, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    exp_q.delete();
    held = '{data: '0, zero: 1'b1, ovf: 1'b0};
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("reset_held");
    rst_n = 1'b1;

    for (int i = 0; i < 100; i++) issue(rand_vec(), ($urandom_range(0, 3) != 0));
    issue(idle, 1'b0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
